// File: rtl/soc_bus_monitor.sv
// Passive monitor on the native memory bus.
// Provides a fetch counter, windowed write trace FIFO, stall watchdog and trap capture.
`timescale 1ns/1ps
module soc_bus_monitor #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int NUM_WIN    = 4,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 32,
    parameter int STALL_MAX  = 1024,
    localparam int STRB_W    = DATA_W / 8,
    localparam int IDX_W     = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1,
    localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic                      clear,
    input  logic                      mem_valid,
    input  logic                      mem_ready,
    input  logic                      mem_instr,
    input  logic [ADDR_W-1:0]         mem_addr,
    input  logic [DATA_W-1:0]         mem_wdata,
    input  logic [STRB_W-1:0]         mem_wstrb,
    input  logic                      trap,
    input  logic [ADDR_W-1:0]         debug_pc,
    input  logic [NUM_WIN*ADDR_W-1:0] win_base,
    input  logic [NUM_WIN*ADDR_W-1:0] win_mask,
    output logic                      trace_valid,
    input  logic                      trace_ready,
    output logic [IDX_W-1:0]          trace_win,
    output logic [STRB_W-1:0]         trace_wstrb,
    output logic [DATA_W-1:0]         trace_data,
    output logic [LVL_W-1:0]          fifo_level,
    output logic                      overflow,
    output logic [CNT_W-1:0]          drop_count,
    output logic [CNT_W-1:0]          insn_count,
    output logic [NUM_WIN*CNT_W-1:0]  win_hits,
    output logic                      stall_err,
    output logic [ADDR_W-1:0]         stall_addr,
    output logic                      trap_seen,
    output logic [ADDR_W-1:0]         trap_pc
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int ENT_W   = IDX_W + STRB_W + DATA_W;
    localparam int STALL_W = $clog2(STALL_MAX + 1);

    logic [NUM_WIN-1:0] hit;
    logic [IDX_W-1:0]   hit_idx;
    logic               xfer;
    logic               push;
    logic               pop;
    logic               full;
    logic               accept;
    logic               drop;
    logic               stalled;
    logic               fetch;
    logic               trap_rise;
    logic               trap_q;
    logic [ENT_W-1:0]   fifo_mem [FIFO_DEPTH];
    logic [ENT_W-1:0]   head;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [LVL_W-1:0]   level;
    logic [CNT_W-1:0]   hit_cnt [NUM_WIN];
    logic [STALL_W-1:0] stall_cnt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign xfer      = mem_valid & mem_ready;
    assign push      = enable & (|hit);
    assign pop       = trace_valid & trace_ready;
    assign full      = (level == LVL_W'(FIFO_DEPTH));
    assign accept    = push & (~full | pop);
    assign drop      = push & full & ~pop;
    assign stalled   = enable & mem_valid & ~mem_ready;
    assign fetch     = enable & xfer & mem_instr;
    assign trap_rise = trap & ~trap_q;

    // Descending scan so the lowest matching window wins the trace index.
    always_comb begin
        hit     = '0;
        hit_idx = '0;
        for (int i = 0; i < NUM_WIN; i++) begin
            hit[i] = xfer && (|mem_wstrb) &&
                     ((mem_addr & win_mask[i*ADDR_W +: ADDR_W]) ==
                      (win_base[i*ADDR_W +: ADDR_W] & win_mask[i*ADDR_W +: ADDR_W]));
        end
        for (int i = NUM_WIN - 1; i >= 0; i--) begin
            if (hit[i]) hit_idx = IDX_W'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (accept && !clear) fifo_mem[wr_ptr] <= {hit_idx, mem_wstrb, mem_wdata};
    end

    // Head is gated so stale storage never leaks out while the FIFO is empty.
    assign trace_valid = (level != '0);
    assign head        = trace_valid ? fifo_mem[rd_ptr] : '0;
    assign {trace_win, trace_wstrb, trace_data} = head;
    assign fifo_level  = level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop)    rd_ptr <= rd_ptr + 1'b1;
            if (accept && !pop)      level <= level + 1'b1;
            else if (pop && !accept) level <= level - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            insn_count <= '0;
            drop_count <= '0;
            overflow   <= 1'b0;
            for (int i = 0; i < NUM_WIN; i++) hit_cnt[i] <= '0;
        end else if (clear) begin
            insn_count <= '0;
            drop_count <= '0;
            overflow   <= 1'b0;
            for (int i = 0; i < NUM_WIN; i++) hit_cnt[i] <= '0;
        end else begin
            if (fetch) insn_count <= sat_inc(insn_count);
            if (drop) begin
                drop_count <= sat_inc(drop_count);
                overflow   <= 1'b1;
            end
            for (int i = 0; i < NUM_WIN; i++) begin
                if (enable && hit[i]) hit_cnt[i] <= sat_inc(hit_cnt[i]);
            end
        end
    end

    for (genvar g = 0; g < NUM_WIN; g++) begin : g_hits
        assign win_hits[g*CNT_W +: CNT_W] = hit_cnt[g];
    end

    // stall_cnt holds the number of stalled edges already seen in this run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt  <= '0;
            stall_err  <= 1'b0;
            stall_addr <= '0;
        end else if (clear) begin
            stall_cnt  <= '0;
            stall_err  <= 1'b0;
            stall_addr <= '0;
        end else begin
            if (!stalled)
                stall_cnt <= '0;
            else if (stall_cnt != STALL_W'(STALL_MAX))
                stall_cnt <= stall_cnt + 1'b1;
            if (stalled && !stall_err && stall_cnt == STALL_W'(STALL_MAX - 1)) begin
                stall_err  <= 1'b1;
                stall_addr <= mem_addr;
            end
        end
    end

    // trap_q keeps sampling through clear so a held trap is not seen as a new edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trap_q    <= 1'b0;
            trap_seen <= 1'b0;
            trap_pc   <= '0;
        end else begin
            trap_q <= trap;
            if (clear) begin
                trap_seen <= 1'b0;
                trap_pc   <= '0;
            end else if (enable && trap_rise && !trap_seen) begin
                trap_seen <= 1'b1;
                trap_pc   <= debug_pc;
            end
        end
    end

endmodule

// File: tb/tb_soc_bus_monitor.sv
// Self-checking bench for soc_bus_monitor: vector table plus scoreboard of expected trace entries.
`timescale 1ns/1ps
module tb_soc_bus_monitor;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int NUM_WIN    = 4;
    localparam int FIFO_DEPTH = 16;
    localparam int CNT_W      = 8;
    localparam int STALL_MAX  = 8;

    logic                      clk;
    logic                      rst_n;
    logic                      enable;
    logic                      clear;
    logic                      mem_valid;
    logic                      mem_ready;
    logic                      mem_instr;
    logic [ADDR_W-1:0]         mem_addr;
    logic [DATA_W-1:0]         mem_wdata;
    logic [3:0]                mem_wstrb;
    logic                      trap;
    logic [ADDR_W-1:0]         debug_pc;
    logic [NUM_WIN*ADDR_W-1:0] win_base;
    logic [NUM_WIN*ADDR_W-1:0] win_mask;
    logic                      trace_valid;
    logic                      trace_ready;
    logic [1:0]                trace_win;
    logic [3:0]                trace_wstrb;
    logic [DATA_W-1:0]         trace_data;
    logic [4:0]                fifo_level;
    logic                      overflow;
    logic [CNT_W-1:0]          drop_count;
    logic [CNT_W-1:0]          insn_count;
    logic [NUM_WIN*CNT_W-1:0]  win_hits;
    logic                      stall_err;
    logic [ADDR_W-1:0]         stall_addr;
    logic                      trap_seen;
    logic [ADDR_W-1:0]         trap_pc;

    soc_bus_monitor #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_WIN(NUM_WIN),
        .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W), .STALL_MAX(STALL_MAX)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_instr(mem_instr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .trap(trap), .debug_pc(debug_pc), .win_base(win_base), .win_mask(win_mask),
        .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_win(trace_win),
        .trace_wstrb(trace_wstrb), .trace_data(trace_data), .fifo_level(fifo_level),
        .overflow(overflow), .drop_count(drop_count), .insn_count(insn_count),
        .win_hits(win_hits), .stall_err(stall_err), .stall_addr(stall_addr),
        .trap_seen(trap_seen), .trap_pc(trap_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] data;
        logic [3:0]  exp_mask;
        logic [1:0]  exp_win;
    } vec_t;

    typedef struct packed {
        logic [1:0]  win;
        logic [3:0]  strb;
        logic [31:0] data;
    } ent_t;

    vec_t       vecs [8];
    ent_t       exp_q [$];
    logic [7:0] exp_insn;
    logic [7:0] exp_drop;
    logic       exp_ovf;
    logic [7:0] exp_hits [4];
    int         checks;
    int         failures;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic checkCounters(input string tag);
        checkOutput({tag, "_insn"}, insn_count, exp_insn);
        checkOutput({tag, "_drop"}, drop_count, exp_drop);
        checkOutput({tag, "_ovf"}, overflow, exp_ovf);
        for (int i = 0; i < NUM_WIN; i++)
            checkOutput($sformatf("%s_hits%0d", tag, i), win_hits[i*CNT_W +: CNT_W], exp_hits[i]);
    endtask

    // One bus cycle: model the pop/push, drive the inputs, then check level after the edge.
    task automatic applyStimulus(input logic v, input logic r, input logic ins,
                                 input logic [31:0] a, input logic [31:0] d,
                                 input logic [3:0] s, input logic tr, input logic [3:0] m);
        ent_t e;
        if (clear) begin
            exp_q.delete();
            exp_insn = '0;
            exp_drop = '0;
            exp_ovf  = 1'b0;
            for (int i = 0; i < NUM_WIN; i++) exp_hits[i] = '0;
        end else begin
            if (tr && exp_q.size() != 0) begin
                checkOutput("pop_win", trace_win, exp_q[0].win);
                checkOutput("pop_strb", trace_wstrb, exp_q[0].strb);
                checkOutput("pop_data", trace_data, exp_q[0].data);
                void'(exp_q.pop_front());
            end
            if (enable && v && r && ins && exp_insn != 8'hFF) exp_insn++;
            if (enable && v && r && s != 4'h0 && m != 4'h0) begin
                e.win = 2'd0;
                for (int i = NUM_WIN - 1; i >= 0; i--) begin
                    if (m[i]) begin
                        e.win = 2'(i);
                        if (exp_hits[i] != 8'hFF) exp_hits[i]++;
                    end
                end
                e.strb = s;
                e.data = d;
                if (exp_q.size() < FIFO_DEPTH) begin
                    exp_q.push_back(e);
                end else begin
                    if (exp_drop != 8'hFF) exp_drop++;
                    exp_ovf = 1'b1;
                end
            end
        end
        mem_valid   = v;
        mem_ready   = r;
        mem_instr   = ins;
        mem_addr    = a;
        mem_wdata   = d;
        mem_wstrb   = s;
        trace_ready = tr;
        @(posedge clk);
        #1;
        checkOutput("fifo_level", fifo_level, exp_q.size());
        checkOutput("trace_valid", trace_valid, exp_q.size() != 0);
    endtask

    task automatic idle(input int n, input logic tr);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 32'h0, 32'h0, 4'h0, tr, 4'h0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks   = 0;
        failures = 0;
        exp_q.delete();
        exp_insn = '0;
        exp_drop = '0;
        exp_ovf  = 1'b0;
        for (int i = 0; i < NUM_WIN; i++) exp_hits[i] = '0;

        vecs[0] = '{32'h2000_0004, 4'h1, 32'h0000_0048, 4'b0011, 2'd0};
        vecs[1] = '{32'h2000_0004, 4'h0, 32'h0000_0099, 4'b0000, 2'd0};
        vecs[2] = '{32'h2000_1008, 4'hF, 32'hDEAD_BEEF, 4'b0010, 2'd1};
        vecs[3] = '{32'h3000_01FC, 4'hC, 32'hCAFE_0000, 4'b0100, 2'd2};
        vecs[4] = '{32'h3000_0200, 4'h2, 32'h0000_1234, 4'b0000, 2'd0};
        vecs[5] = '{32'h4ABC_DEF0, 4'h8, 32'h0000_0055, 4'b1000, 2'd3};
        vecs[6] = '{32'h2000_0FFC, 4'h3, 32'h0000_0077, 4'b0011, 2'd0};
        vecs[7] = '{32'h1FFF_FFFC, 4'hF, 32'h0000_0088, 4'b0000, 2'd0};

        rst_n       = 1'b0;
        enable      = 1'b0;
        clear       = 1'b0;
        mem_valid   = 1'b0;
        mem_ready   = 1'b0;
        mem_instr   = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_wstrb   = '0;
        trap        = 1'b0;
        debug_pc    = '0;
        trace_ready = 1'b0;
        win_base    = {32'h4000_0000, 32'h3000_0100, 32'h2000_0000, 32'h2000_0000};
        win_mask    = {32'hF000_0000, 32'hFFFF_FF00, 32'hFFFF_0000, 32'hFFFF_F000};

        #12;
        checkOutput("rst_trace_valid", trace_valid, 0);
        checkOutput("rst_fifo_level", fifo_level, 0);
        checkOutput("rst_trace_data", trace_data, 0);
        checkOutput("rst_stall_err", stall_err, 0);
        checkOutput("rst_trap_seen", trap_seen, 0);
        checkCounters("rst");
        #5;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        enable = 1'b1;

        $display("[TB] window match table");
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1, 1, 0, vecs[k].addr, vecs[k].data, vecs[k].wstrb, 0, vecs[k].exp_mask);
            if (vecs[k].exp_mask != 4'h0)
                checkOutput($sformatf("table%0d_win", k), trace_win, vecs[k].exp_win);
            idle(1, 1);
        end
        checkOutput("table_hits0", win_hits[7:0], 2);
        checkOutput("table_hits1", win_hits[15:8], 3);
        checkOutput("table_hits2", win_hits[23:16], 1);
        checkOutput("table_hits3", win_hits[31:24], 1);

        $display("[TB] overflow and drain");
        for (int k = 0; k < 18; k++)
            applyStimulus(1, 1, 0, 32'h2000_0000 + k * 4, 32'h100 + k, 4'hF, 0, 4'b0011);
        checkOutput("ovf_level", fifo_level, 16);
        checkOutput("ovf_flag", overflow, 1);
        checkOutput("ovf_drop", drop_count, 2);
        idle(16, 1);
        checkOutput("drained_valid", trace_valid, 0);
        idle(1, 1);

        $display("[TB] push and pop while full");
        for (int k = 0; k < 16; k++)
            applyStimulus(1, 1, 0, 32'h2000_0080, 32'h200 + k, 4'h5, 0, 4'b0011);
        applyStimulus(1, 1, 0, 32'h2000_0100, 32'h2FF, 4'hF, 1, 4'b0011);
        checkOutput("fullpp_level", fifo_level, 16);
        checkOutput("fullpp_drop", drop_count, 2);
        idle(16, 1);
        checkCounters("after_fifo");

        $display("[TB] stall watchdog");
        for (int k = 0; k < 7; k++) applyStimulus(1, 0, 0, 32'h1000, 0, 4'h0, 0, 4'h0);
        applyStimulus(1, 1, 0, 32'h1000, 0, 4'h0, 0, 4'h0);
        checkOutput("stall7_err", stall_err, 0);
        for (int k = 0; k < 7; k++) applyStimulus(1, 0, 0, 32'h1000, 0, 4'h0, 0, 4'h0);
        checkOutput("stall7b_err", stall_err, 0);
        applyStimulus(1, 0, 0, 32'h1000, 0, 4'h0, 0, 4'h0);
        checkOutput("stall8_err", stall_err, 1);
        checkOutput("stall8_addr", stall_addr, 32'h1000);
        for (int k = 0; k < 10; k++) applyStimulus(1, 0, 0, 32'h2000, 0, 4'h0, 0, 4'h0);
        checkOutput("stall_keep_addr", stall_addr, 32'h1000);
        idle(1, 0);

        $display("[TB] trap capture");
        trap     = 1'b1;
        debug_pc = 32'h104;
        idle(1, 0);
        debug_pc = 32'h150;
        idle(4, 0);
        trap = 1'b0;
        idle(2, 0);
        trap     = 1'b1;
        debug_pc = 32'h200;
        idle(1, 0);
        trap = 1'b0;
        idle(1, 0);
        checkOutput("trap_seen", trap_seen, 1);
        checkOutput("trap_pc", trap_pc, 32'h104);

        clear = 1'b1;
        idle(1, 0);
        clear = 1'b0;
        checkOutput("clr_trap_seen", trap_seen, 0);
        checkOutput("clr_trap_pc", trap_pc, 0);
        checkOutput("clr_stall_err", stall_err, 0);
        checkOutput("clr_stall_addr", stall_addr, 0);
        checkCounters("clr");

        trap     = 1'b1;
        debug_pc = 32'h300;
        idle(1, 0);
        checkOutput("trap2_pc", trap_pc, 32'h300);
        clear = 1'b1;
        idle(1, 0);
        clear = 1'b0;
        idle(1, 0);
        checkOutput("held_trap_seen", trap_seen, 0);
        trap = 1'b0;
        idle(1, 0);

        enable   = 1'b0;
        trap     = 1'b1;
        debug_pc = 32'h400;
        idle(1, 0);
        enable = 1'b1;
        idle(1, 0);
        checkOutput("dis_trap_seen", trap_seen, 0);
        trap = 1'b0;

        $display("[TB] enable gating and saturation");
        enable = 1'b0;
        for (int k = 0; k < 10; k++) applyStimulus(1, 1, 1, 32'h100 + k * 4, 0, 4'h0, 0, 4'h0);
        applyStimulus(1, 1, 0, 32'h2000_0000, 32'h11, 4'hF, 0, 4'b0011);
        for (int k = 0; k < 10; k++) applyStimulus(1, 0, 0, 32'h3000, 0, 4'h0, 0, 4'h0);
        checkOutput("dis_insn", insn_count, 0);
        checkOutput("dis_stall_err", stall_err, 0);
        enable = 1'b1;
        for (int k = 0; k < 3; k++) applyStimulus(1, 1, 1, 32'h200 + k * 4, 0, 4'h0, 0, 4'h0);
        checkOutput("en_insn", insn_count, 3);
        for (int k = 0; k < 260; k++) applyStimulus(1, 1, 1, 32'h300, 0, 4'h0, 0, 4'h0);
        checkOutput("sat_insn", insn_count, 8'hFF);
        checkCounters("sat");

        $display("[TB] asynchronous reset with queued entries");
        for (int k = 0; k < 5; k++)
            applyStimulus(1, 1, 0, 32'h2000_0010, 32'h500 + k, 4'hF, 0, 4'b0011);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_valid", trace_valid, 0);
        checkOutput("arst_level", fifo_level, 0);
        checkOutput("arst_data", trace_data, 0);
        checkOutput("arst_insn", insn_count, 0);
        checkOutput("arst_hits", win_hits, 0);
        checkOutput("arst_trap_pc", trap_pc, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/soc_bus_monitor.md
Name: soc_bus_monitor

Overview:
Synthesizable, parametrised hardware monitor on the SoC native memory bus (mem_valid/mem_ready handshake). It snoops completed transfers without ever driving the bus. Its functions:
- counts instruction fetches;
- matches writes against NUM_WIN programmable address windows and queues matched writes in a trace FIFO for readout;
- detects bus stalls and latches trap events.

It sits beside the CPU on the bus and replaces ad-hoc simulation-only snooping with on-chip debug state.

Parameters:
ADDR_W, 32, bus address width
DATA_W, 32, bus data width (multiple of 8); STRB_W = DATA_W/8
NUM_WIN, 4, number of address match windows (1..8); IDX_W = max(1, clog2(NUM_WIN))
FIFO_DEPTH, 16, trace FIFO entries (power of 2, >=2)
CNT_W, 32, width of all event counters
STALL_MAX, 1024, consecutive stalled cycles that raise stall_err (>=2)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  1 = monitor active; 0 = no counting, capture or stall tracking
clear  in  1  synchronous clear of counters, sticky flags and FIFO
mem_valid  in  1  bus request valid
mem_ready  in  1  bus request accepted
mem_instr  in  1  request is an instruction fetch
mem_addr  in  ADDR_W  bus address
mem_wdata  in  DATA_W  write data
mem_wstrb  in  STRB_W  byte strobes (0 = read)
trap  in  1  CPU trap
debug_pc  in  ADDR_W  current CPU PC
win_base  in  NUM_WIN*ADDR_W  window i base at [i*ADDR_W +: ADDR_W]
win_mask  in  NUM_WIN*ADDR_W  window i compare mask
trace_valid  out  1  FIFO head valid
trace_ready  in  1  consumer pops head
trace_win  out  IDX_W  head window index
trace_wstrb  out  STRB_W  head strobes
trace_data  out  DATA_W  head write data
fifo_level  out  clog2(FIFO_DEPTH)+1  occupied entries
overflow  out  1  sticky: a push was dropped
drop_count  out  CNT_W  dropped pushes
insn_count  out  CNT_W  completed fetches
win_hits  out  NUM_WIN*CNT_W  per-window write hit counts
stall_err  out  1  sticky stall error
stall_addr  out  ADDR_W  address of first stall error
trap_seen  out  1  sticky trap flag
trap_pc  out  ADDR_W  debug_pc at first trap rising edge

Behaviour:
Reset and event definitions:
- Reset (async assert, sync release): every output 0, FIFO empty, internal counters and trap edge register 0. Reset mid-operation discards FIFO contents immediately.
- Transfer: mem_valid & mem_ready at a clk edge.
- Fetch: transfer & mem_instr. Increments insn_count.
- Window write hit i: transfer & |mem_wstrb & ((mem_addr & mask_i) == (base_i & mask_i)).

Counters and trace capture:
- win_hits[i] increments for every matching window independently.
- Trace push on any hit. Entry = {lowest matching index, wstrb, wdata}. Reads never push.
- All counters saturate at all-ones and never wrap.

FIFO:
- Registered FIFO. A pushed entry is visible on trace_* the cycle after the push edge.
- Pop = trace_valid & trace_ready.
- Push while full with no pop: entry dropped, overflow set, drop_count incremented.
- Push while full with a pop in the same cycle: push accepted, level unchanged.
- Simultaneous push/pop at any level: level unchanged, order preserved.
- Pop when empty: ignored.
- Pointers wrap modulo FIFO_DEPTH.

Stall watchdog:
- stall_cnt increments on each edge with mem_valid & !mem_ready.
- stall_cnt resets to 0 on mem_ready or !mem_valid.
- On the edge where the stalled cycle is the STALL_MAX-th consecutive one: stall_err sets and stall_addr = mem_addr.
- Only the first stall error is captured until clear. stall_cnt saturates.

Trap capture:
- trap is registered each cycle.
- On a rising edge (trap & !trap_q) while trap_seen=0: trap_seen=1, trap_pc=debug_pc.
- A held trap level or later edges do not recapture.

enable:
- enable=0 blocks counting, pushes, stall tracking (stall_cnt held at 0) and trap capture.
- Pops and trap_q sampling continue while enable=0.

clear:
- Zeroes counters, sticky flags, stall_addr, trap_pc and stall_cnt, and empties the FIFO.
- Has priority over any same-cycle event, including a push or pop.
- trap_q keeps sampling during clear, so a trap held through clear is not re-captured.

Latency: all status outputs update at the edge following the event, with no combinational path from the bus to any output.

Test Plan:
1. Window 0 base 0x20000000 mask 0xFFFFF000; write 0x48, wstrb 0001 to 0x20000004 -> next cycle trace_valid=1, trace_win=0, trace_data=0x48, win_hits[0]=1. Read to the same address -> no push.
2. trace_ready=0, 18 hit writes with FIFO_DEPTH=16 -> fifo_level=16, overflow=1, drop_count=2. Drain -> first 16 data values in order, then trace_valid=0.
3. Windows 0 and 1 both matching 0x20000000 -> trace_win=0, win_hits[0]=win_hits[1]=1. Full FIFO with push+pop in the same cycle -> level stays 16, no drop.
4. STALL_MAX=8. mem_valid=1, mem_ready=0 for 7 cycles then ready -> stall_err=0. Repeat for 8 cycles at addr 0x00001000 -> stall_err=1, stall_addr=0x00001000.
5. trap rises with debug_pc=0x00000104, held 5 cycles, then a second pulse at PC 0x200 -> trap_pc=0x104. clear with trap low -> trap_seen=0, trap_pc=0.
6. 10 fetches with enable=0, then 3 with enable=1 -> insn_count=3. Assert rst_n=0 with 5 FIFO entries -> all outputs 0 asynchronously.
